mmio_io_ctrl: RTL and testbench
===============================

# mmio_io_ctrl

Parametrised memory-mapped I/O controller for the single-cycle CPU. It replaces the fixed KEY/SW/HEX/LEDR/LEDG decode inside data memory and handles any channel counts. It adds input synchronisation, per-bit debouncing, sticky edge capture with write-1-to-clear, and a maskable registered interrupt. It sits beside data memory on the CPU load/store bus; data memory muxes `rd_data` in when `hit` is high.

## Interface
- `DBITS`, 32, bus data/address width
- `BASE_ADDR`, 32'hF0000000, 64-byte-aligned base of the I/O window
- `NUM_KEYS`, 4, push-button inputs (active-low at pin)
- `NUM_SW`, 10, slide-switch inputs
- `NUM_LEDR`, 10, red LED outputs
- `NUM_LEDG`, 8, green LED outputs
- `NUM_HEX`, 4, seven-segment digits (4 bits each)
- `DEBOUNCE_CYCLES`, 16, stable cycles required before a debounced bit changes; legal range ≥1
- Legal-configuration constraint: NUM_KEYS+NUM_SW ≤ DBITS, and NUM_LEDR, NUM_LEDG, 4*NUM_HEX each ≤ DBITS.

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `addr`  in  DBITS  byte address from ALU result
- `wr_en`  in  1  store strobe
- `wr_data`  in  DBITS  store data
- `rd_data`  out  DBITS  combinational read data
- `hit`  out  1  combinational; addr[DBITS-1:6] == BASE_ADDR[DBITS-1:6]
- `key_in`  in  NUM_KEYS  raw keys, asynchronous, active-low
- `sw_in`  in  NUM_SW  raw switches, asynchronous
- `ledr_out`  out  NUM_LEDR  red LEDs
- `ledg_out`  out  NUM_LEDG  green LEDs
- `hex_out`  out  4*NUM_HEX  hex nibbles, digit 0 in [3:0]
- `irq`  out  1  registered interrupt request

## Operation
- Register map. The offset is addr[5:2]×4.
  - 0x00 HEX: read/write.
  - 0x04 LEDR: read/write.
  - 0x08 LEDG: read/write.
  - 0x10 KEY: read-only, debounced, active-high (pressed=1).
  - 0x14 SW: read-only, debounced.
  - 0x20 KEDGE: W1C, sticky.
  - 0x24 SEDGE: W1C, sticky.
  - 0x28 IRQ_MASK: read/write; [NUM_KEYS-1:0] key mask, [NUM_KEYS+NUM_SW-1:NUM_KEYS] switch mask.
  - All other offsets read 0 and ignore writes.
- Register widths:
  - Writable registers store only their low N bits.
  - Reads are zero-extended to DBITS.
  - Writes to read-only registers are ignored.
- A write is performed only when `wr_en && hit`. `rd_data` is 0 when `hit` is low.
- Input path:
  - Each key and switch bit passes through a 2-flop synchroniser. Keys are inverted after synchronisation.
  - Each bit then goes to an independent debouncer with a counter of width $clog2(DEBOUNCE_CYCLES+1).
- Debouncer behaviour:
  - Synced == debounced: counter = 0.
  - Synced != debounced: counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 while the bit still differs, the debounced bit flips on the next edge and the counter clears.
  - Any glitch back to equality restarts the counter.
- Edge capture:
  - KEDGE[i] sets on a debounced key 0→1 transition.
  - SEDGE[j] sets on any debounced switch change.
  - Writing 1 clears a bit; writing 0 has no effect.
  - If a set and a W1C of the same bit land in the same cycle, set wins.
- `irq` is the registered value of |((SEDGE,KEDGE) & IRQ_MASK).

## Timing
- Reset state:
  - All writable registers = 0.
  - Synchronisers, debounced values, counters, KEDGE and SEDGE = 0.
  - `irq` = 0.
  - `ledr_out`, `ledg_out` and `hex_out` = 0 in the cycle after reset is sampled.
- Write latency:
  - The output register is updated at the clock edge where the write is sampled.
  - LED/HEX pins reflect the new value in the following cycle. They are driven directly from the registers.
- Read latency: 0 cycles (combinational from register state).
- Input latency: a raw change held stable appears in KEY/SW after exactly 2 + DEBOUNCE_CYCLES edges. The edge bit sets on that same edge. `irq` rises one edge later.
- After reset, a switch already held at 1 debounces 0→1 and sets SEDGE. This is required behaviour; software clears it at boot.
- `reset` asserted mid-debounce discards the count. No edge is recorded.

## Configuration
- `MMIO_IO_CTRL_EDGE_EN` defined:
  - The KEDGE, SEDGE and IRQ_MASK registers and the `irq` logic are built.
- Not defined:
  - Offsets 0x20/0x24/0x28 read 0 and ignore writes.
  - `irq` is tied to 0.
  - No edge or mask flops are synthesised.
  - Debounce and all other behaviour are unchanged.

## Test plan
- Reset, then store 0x1234 to 0xF0000000 and 0x3FF to 0xF0000004 → `hex_out`=0x1234 and `ledr_out`=0x3FF the next cycle; reads return the same values.
- Drop key_in[2] to 0, hold 20 cycles (DEBOUNCE_CYCLES=16) → KEY reads 0x4 at edge 18 after the change and not before; KEDGE=0x4.
- Toggle sw_in[0] every 5 cycles for 100 cycles, then hold at 1 → SW[0] changes only after 16 stable cycles; SEDGE[0] sets exactly once after the hold.
- Set IRQ_MASK=0x1 and press key 0 → `irq`=1 one cycle after KEDGE[0] sets. Write 0x1 to 0xF0000020 → KEDGE=0 and `irq` drops next cycle.
- Issue a W1C of KEDGE[1] in the same cycle a new key-1 press is detected → KEDGE[1] remains 1.
- Store to 0xF0000010 and to 0xF0000038; read 0xE0000000 → KEY is unchanged, 0x38 reads 0, `hit`=0 and `rd_data`=0.

Source files
------------

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: memory-mapped KEY/SW/LEDR/LEDG/HEX controller with synchronised, debounced inputs.
// Edge capture, interrupt mask and irq are built only when MMIO_IO_CTRL_EDGE_EN is defined.
module mmio_io_ctrl #(
   parameter int unsigned     DBITS           = 32,
   parameter logic [DBITS-1:0] BASE_ADDR      = DBITS'(32'hF0000000),
   parameter int unsigned     NUM_KEYS        = 4,
   parameter int unsigned     NUM_SW          = 10,
   parameter int unsigned     NUM_LEDR        = 10,
   parameter int unsigned     NUM_LEDG        = 8,
   parameter int unsigned     NUM_HEX         = 4,
   parameter int unsigned     DEBOUNCE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DBITS-1:0]      addr,
   input  logic                  wr_en,
   input  logic [DBITS-1:0]      wr_data,
   output logic [DBITS-1:0]      rd_data,
   output logic                  hit,
   input  logic [NUM_KEYS-1:0]   key_in,
   input  logic [NUM_SW-1:0]     sw_in,
   output logic [NUM_LEDR-1:0]   ledr_out,
   output logic [NUM_LEDG-1:0]   ledg_out,
   output logic [4*NUM_HEX-1:0]  hex_out,
   output logic                  irq
);

   localparam int unsigned NB    = NUM_KEYS + NUM_SW;
   localparam int unsigned HEX_W = 4 * NUM_HEX;
   localparam int unsigned CW    = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [3:0] OFF_HEX   = 4'h0;
   localparam logic [3:0] OFF_LEDR  = 4'h1;
   localparam logic [3:0] OFF_LEDG  = 4'h2;
   localparam logic [3:0] OFF_KEY   = 4'h4;
   localparam logic [3:0] OFF_SW    = 4'h5;
   localparam logic [3:0] OFF_KEDGE = 4'h8;
   localparam logic [3:0] OFF_SEDGE = 4'h9;
   localparam logic [3:0] OFF_MASK  = 4'hA;

   logic [3:0]    offset_c;
   logic          wr_hit_c;
   logic [NB-1:0] sync1, sync2, synced_c, deb, flip_c;
   logic [CW-1:0] cnt [NB];
   logic          unused_ok_c;

   assign offset_c    = addr[5:2];
   assign hit         = (addr[DBITS-1:6] == BASE_ADDR[DBITS-1:6]);
   assign wr_hit_c    = wr_en & hit;
   assign unused_ok_c = &{1'b0, addr[1:0], wr_data};

   // Two-flop synchroniser; switches in the upper bits, keys in the lower bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {sw_in, key_in};
         sync2 <= sync1;
      end
   end

   // Keys are active-low at the pin; present them as pressed=1.
   assign synced_c = {sync2[NB-1:NUM_KEYS], ~sync2[NUM_KEYS-1:0]};

   always_comb begin
      flip_c = '0;
      for (int i = 0; i < int'(NB); i++) begin
         flip_c[i] = (synced_c[i] != deb[i]) && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
      end
   end

   // Per-bit debouncer: count consecutive disagreeing samples, flip after DEBOUNCE_CYCLES.
   always_ff @(posedge clk) begin
      if (reset) begin
         deb <= '0;
         for (int i = 0; i < int'(NB); i++) cnt[i] <= '0;
      end else begin
         deb <= deb ^ flip_c;
         for (int i = 0; i < int'(NB); i++) begin
            if ((synced_c[i] == deb[i]) || flip_c[i]) cnt[i] <= '0;
            else                                      cnt[i] <= cnt[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hex_out  <= '0;
         ledr_out <= '0;
         ledg_out <= '0;
      end else if (wr_hit_c) begin
         case (offset_c)
            OFF_HEX:  hex_out  <= wr_data[HEX_W-1:0];
            OFF_LEDR: ledr_out <= wr_data[NUM_LEDR-1:0];
            OFF_LEDG: ledg_out <= wr_data[NUM_LEDG-1:0];
            default:  ;
         endcase
      end
   end

`ifdef MMIO_IO_CTRL_EDGE_EN
   logic [NUM_KEYS-1:0] kedge, kset_c, kclr_c;
   logic [NUM_SW-1:0]   sedge, sset_c, sclr_c;
   logic [NB-1:0]       irq_mask;

   assign kset_c = flip_c[NUM_KEYS-1:0] & ~deb[NUM_KEYS-1:0];
   assign sset_c = flip_c[NB-1:NUM_KEYS];
   assign kclr_c = (wr_hit_c && (offset_c == OFF_KEDGE)) ? wr_data[NUM_KEYS-1:0] : '0;
   assign sclr_c = (wr_hit_c && (offset_c == OFF_SEDGE)) ? wr_data[NUM_SW-1:0] : '0;

   // Sticky edges; a set on the same edge as a clear wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         kedge    <= '0;
         sedge    <= '0;
         irq_mask <= '0;
         irq      <= 1'b0;
      end else begin
         kedge <= (kedge & ~kclr_c) | kset_c;
         sedge <= (sedge & ~sclr_c) | sset_c;
         if (wr_hit_c && (offset_c == OFF_MASK)) irq_mask <= wr_data[NB-1:0];
         irq <= |({sedge, kedge} & irq_mask);
      end
   end
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      rd_data = '0;
      if (hit) begin
         case (offset_c)
            OFF_HEX:   rd_data = DBITS'(hex_out);
            OFF_LEDR:  rd_data = DBITS'(ledr_out);
            OFF_LEDG:  rd_data = DBITS'(ledg_out);
            OFF_KEY:   rd_data = DBITS'(deb[NUM_KEYS-1:0]);
            OFF_SW:    rd_data = DBITS'(deb[NB-1:NUM_KEYS]);
`ifdef MMIO_IO_CTRL_EDGE_EN
            OFF_KEDGE: rd_data = DBITS'(kedge);
            OFF_SEDGE: rd_data = DBITS'(sedge);
            OFF_MASK:  rd_data = DBITS'(irq_mask);
`endif
            default:   rd_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: vector table, directed latency/edge/irq sequences, then randomized traffic
// compared against a sample-window reference model of the I/O controller.
module tb_mmio_io_ctrl;

   localparam int unsigned NUM_KEYS = 4;
   localparam int unsigned NUM_SW   = 10;
   localparam int unsigned NB       = NUM_KEYS + NUM_SW;
   localparam int unsigned DB       = 16;
   localparam logic [31:0] BASE     = 32'hF0000000;
`ifdef MMIO_IO_CTRL_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, wr_data, rd_data;
   logic        wr_en, hit, irq;
   logic [3:0]  key_in;
   logic [9:0]  sw_in, ledr_out;
   logic [7:0]  ledg_out;
   logic [15:0] hex_out;

   always #5 clk = ~clk;

   mmio_io_ctrl dut (
      .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
      .rd_data(rd_data), .hit(hit), .key_in(key_in), .sw_in(sw_in),
      .ledr_out(ledr_out), .ledg_out(ledg_out), .hex_out(hex_out), .irq(irq)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: debounced bit flips once the last DB synced samples all disagree with it.
   logic [15:0]   m_hex;
   logic [9:0]    m_ledr, m_sedge;
   logic [7:0]    m_ledg;
   logic [3:0]    m_kedge;
   logic [NB-1:0] m_mask, m_deb, m_pin1, m_pin2;
   logic          m_irq;
   logic [NB-1:0] m_win[$];

   always @(posedge clk) begin
      logic [NB-1:0] seen, newdeb, changed;
      bit all_diff;
      if (reset) begin
         m_hex = '0; m_ledr = '0; m_ledg = '0; m_mask = '0; m_deb = '0;
         m_kedge = '0; m_sedge = '0; m_irq = 1'b0; m_pin1 = '0; m_pin2 = '0;
         m_win.delete();
      end else begin
         m_irq = EDGE_EN && (|({m_sedge, m_kedge} & m_mask));
         if (wr_en && (addr[31:6] == BASE[31:6])) begin
            case (addr[5:2])
               4'h0: m_hex  = wr_data[15:0];
               4'h1: m_ledr = wr_data[9:0];
               4'h2: m_ledg = wr_data[7:0];
               4'h8: m_kedge = m_kedge & ~wr_data[3:0];
               4'h9: m_sedge = m_sedge & ~wr_data[9:0];
               4'hA: if (EDGE_EN) m_mask = wr_data[NB-1:0];
               default: ;
            endcase
         end
         seen = m_pin2;
         seen[3:0] = ~seen[3:0];
         m_pin2 = m_pin1;
         m_pin1 = {sw_in, key_in};
         m_win.push_back(seen);
         if (m_win.size() > DB) void'(m_win.pop_front());
         newdeb = m_deb;
         if (m_win.size() == DB) begin
            for (int b = 0; b < int'(NB); b++) begin
               all_diff = 1'b1;
               for (int k = 0; k < int'(DB); k++) if (m_win[k][b] == m_deb[b]) all_diff = 1'b0;
               if (all_diff) newdeb[b] = ~m_deb[b];
            end
         end
         changed = newdeb ^ m_deb;
         m_kedge = m_kedge | (changed[3:0] & newdeb[3:0]);
         m_sedge = m_sedge | changed[NB-1:4];
         m_deb   = newdeb;
      end
   end

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (a[31:6] != BASE[31:6]) return 32'h0;
      case (a[5:2])
         4'h0: return 32'(m_hex);
         4'h1: return 32'(m_ledr);
         4'h2: return 32'(m_ledg);
         4'h4: return 32'(m_deb[3:0]);
         4'h5: return 32'(m_deb[NB-1:4]);
         4'h8: return EDGE_EN ? 32'(m_kedge) : 32'h0;
         4'h9: return EDGE_EN ? 32'(m_sedge) : 32'h0;
         4'hA: return EDGE_EN ? 32'(m_mask) : 32'h0;
         default: return 32'h0;
      endcase
   endfunction

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr = a; wr_en = 1'b1; wr_data = d;
      @(posedge clk);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic read_chk(input string n, input logic [31:0] a, input logic [31:0] e);
      addr = a; wr_en = 1'b0;
      #1;
      check(n, rd_data, e);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic        hit;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   initial begin
      int   seen_at, rises;
      logic prev_se;
      vecs[0]  = '{32'hF0000000, 1'b1, 32'h00001234, 32'h1234, 1'b1};
      vecs[1]  = '{32'hF0000004, 1'b1, 32'h000003FF, 32'h03FF, 1'b1};
      vecs[2]  = '{32'hF0000008, 1'b1, 32'hFFFFFFFF, 32'h00FF, 1'b1};
      vecs[3]  = '{32'hF0000000, 1'b1, 32'hABCDEF12, 32'hEF12, 1'b1};
      vecs[4]  = '{32'hF0000004, 1'b1, 32'hFFFFFC01, 32'h0001, 1'b1};
      vecs[5]  = '{32'hF0000038, 1'b1, 32'hFFFFFFFF, 32'h0000, 1'b1};
      vecs[6]  = '{32'hF000000C, 1'b1, 32'h00000005, 32'h0000, 1'b1};
      vecs[7]  = '{32'hE0000000, 1'b1, 32'h00000055, 32'h0000, 1'b0};
      vecs[8]  = '{32'hF0000040, 1'b1, 32'h00000077, 32'h0000, 1'b0};
      vecs[9]  = '{32'hF0000010, 1'b1, 32'h0000000F, 32'h0000, 1'b1};
      vecs[10] = '{32'hF0000000, 1'b0, 32'h00000000, 32'hEF12, 1'b1};
      vecs[11] = '{32'hF0000008, 1'b0, 32'h00000000, 32'h00FF, 1'b1};
      vecs[12] = '{32'hF0000028, 1'b1, 32'hFFFFFFFF, EDGE_EN ? 32'h3FFF : 32'h0, 1'b1};
      vecs[13] = '{32'hF0000028, 1'b1, 32'h00000000, 32'h0000, 1'b1};
      vecs[14] = '{32'hF0000014, 1'b1, 32'h0000FFFF, 32'h0000, 1'b1};
      vecs[15] = '{32'hF000003C, 1'b0, 32'h00000000, 32'h0000, 1'b1};

      reset = 1'b1; key_in = 4'hF; sw_in = '0; wr_en = 1'b0; addr = '0; wr_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_ledr", 32'(ledr_out), 32'h0);
      check("rst_ledg", 32'(ledg_out), 32'h0);
      check("rst_hex", 32'(hex_out), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      read_chk("rst_key", BASE + 32'h10, 32'h0);
      read_chk("rst_sw", BASE + 32'h14, 32'h0);

      // Pins follow a store one cycle later.
      bus_write(BASE, 32'h1234);
      check("pin_hex", 32'(hex_out), 32'h1234);
      bus_write(BASE + 32'h4, 32'h3FF);
      check("pin_ledr", 32'(ledr_out), 32'h3FF);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         addr = vecs[i].addr; wr_en = vecs[i].we; wr_data = vecs[i].wdata;
         @(posedge clk);
         @(negedge clk);
         wr_en = 1'b0;
         #1;
         check($sformatf("vec%0d_rd", i), rd_data, vecs[i].rd);
         check($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].hit));
      end
      check("tbl_hex", 32'(hex_out), 32'hEF12);
      check("tbl_ledr", 32'(ledr_out), 32'h001);
      check("tbl_ledg", 32'(ledg_out), 32'hFF);

      // Key 2 press: KEY must change on edge 18 exactly.
      @(negedge clk);
      key_in[2] = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         read_chk($sformatf("key2_e%0d", k), BASE + 32'h10, (k >= 18) ? 32'h4 : 32'h0);
      end
      read_chk("key2_kedge", BASE + 32'h20, EDGE_EN ? 32'h4 : 32'h0);
      key_in[2] = 1'b1;
      repeat (25) @(posedge clk);
      bus_write(BASE + 32'h20, 32'hF);
      read_chk("key2_w1c", BASE + 32'h20, 32'h0);
      read_chk("key2_rel", BASE + 32'h10, 32'h0);

      // Switch 0 chatter, then a stable hold at 1.
      rises = 0;
      prev_se = 1'b0;
      for (int c = 0; c < 130; c++) begin
         @(negedge clk);
         if (c < 100 && (c % 5) == 0) sw_in[0] = ~sw_in[0];
         if (c == 100) sw_in[0] = 1'b1;
         read_chk($sformatf("sw0_c%0d", c), BASE + 32'h14, (c >= 118) ? 32'h1 : 32'h0);
         addr = BASE + 32'h24;
         #1;
         if (rd_data[0] && !prev_se) rises++;
         prev_se = rd_data[0];
      end
      check("sedge0_sets", 32'(rises), EDGE_EN ? 32'h1 : 32'h0);
      bus_write(BASE + 32'h24, 32'h1);
      read_chk("sedge0_w1c", BASE + 32'h24, 32'h0);

      // Masked key 0 interrupt, then clear.
      bus_write(BASE + 32'h28, 32'h1);
      @(negedge clk);
      key_in[0] = 1'b0;
      seen_at = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         addr = BASE + 32'h10;
         #1;
         if (rd_data[0]) begin
            seen_at = k;
            break;
         end
      end
      check("key0_latency", 32'(seen_at), 32'd18);
      check("irq_not_yet", 32'(irq), 32'h0);
      read_chk("key0_kedge", BASE + 32'h20, EDGE_EN ? 32'h1 : 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("irq_rise", 32'(irq), 32'(EDGE_EN));
      bus_write(BASE + 32'h20, 32'h1);
      read_chk("kedge0_w1c", BASE + 32'h20, 32'h0);
      check("irq_hold", 32'(irq), 32'(EDGE_EN));
      @(posedge clk);
      @(negedge clk);
      check("irq_drop", 32'(irq), 32'h0);
      key_in[0] = 1'b1;
      repeat (25) @(posedge clk);

      // W1C of KEDGE[1] lands on the edge that detects the key-1 press.
      @(negedge clk);
      key_in[1] = 1'b0;
      repeat (17) @(posedge clk);
      @(negedge clk);
      addr = BASE + 32'h20; wr_en = 1'b1; wr_data = 32'h2;
      @(posedge clk);
      @(negedge clk);
      wr_en = 1'b0;
      read_chk("key1_key", BASE + 32'h10, 32'h2);
      read_chk("key1_set_wins", BASE + 32'h20, EDGE_EN ? 32'h2 : 32'h0);
      key_in[1] = 1'b1;
      repeat (25) @(posedge clk);

      // Randomized traffic against the reference model, including resets mid-debounce.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 9) == 0) begin
            int b;
            b = int'($urandom_range(0, NB - 1));
            if (b < int'(NUM_KEYS)) key_in[b] = ~key_in[b];
            else                    sw_in[b - int'(NUM_KEYS)] = ~sw_in[b - int'(NUM_KEYS)];
         end
         if ($urandom_range(0, 7) == 0) addr = $urandom;
         else                            addr = BASE | (32'($urandom_range(0, 15)) << 2);
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_data = $urandom;
         #1;
         check("rnd_rd", rd_data, m_read(addr));
         check("rnd_hit", 32'(hit), 32'(addr[31:6] == BASE[31:6]));
         check("rnd_hex", 32'(hex_out), 32'(m_hex));
         check("rnd_ledr", 32'(ledr_out), 32'(m_ledr));
         check("rnd_ledg", 32'(ledg_out), 32'(m_ledg));
         check("rnd_irq", 32'(irq), 32'(m_irq));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
